// File: rtl/cnn_layer_accel_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_layer_accel_seq_pkg
// Description : Shared types and helpers for the weight-sequence controller:
//               FSM state encoding, default issue length, gray stepping.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_layer_accel_seq_pkg;

    // Issues per kernel-column group
    localparam int unsigned SEQ_LEN_DEFAULT = 5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ROW_WAIT = 2'd1,
        ST_SEQ      = 2'd2,
        ST_DONE     = 2'd3
    } seq_state_t;

    // Row phase advances 00 -> 01 -> 11 -> 10 -> 00
    function automatic logic [1:0] gray_next(input logic [1:0] gray);
        logic [1:0] nxt;
        case (gray)
            2'b00:   nxt = 2'b01;
            2'b01:   nxt = 2'b11;
            2'b11:   nxt = 2'b10;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_layer_accel_wrap_counter.sv
`default_nettype none
// ============================================================================
// Module      : cnn_layer_accel_wrap_counter
// Description : Enabled up-counter that wraps to zero after its last value.
//               MODULUS > 0 fixes the terminal count at elaboration;
//               MODULUS == 0 takes the terminal count from last_val.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_layer_accel_wrap_counter #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] last_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] c_FIXED_LAST = (MODULUS > 0) ? WIDTH'(MODULUS - 1) : '0;

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_last;

    assign w_last = (MODULUS > 0) ? c_FIXED_LAST : last_val;
    assign wrap   = en && (r_count == w_last);
    assign count  = r_count;

    // Count enabled events, returning to zero after the terminal value
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= wrap ? '0 : r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cnn_layer_accel_weight_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cnn_layer_accel_weight_seq_ctrl
// Description : Sequences weight-table reads for one CNN layer pass:
//               rows x column-groups x SEQ_LEN issues, with row-buffer
//               handshake, downstream stall and a gray-coded row phase.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_layer_accel_weight_seq_ctrl
    import cnn_layer_accel_seq_pkg::*;
#(
    parameter int SEQ_LEN = SEQ_LEN_DEFAULT,
    parameter int CNT_W   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_num_rows,
    input  logic [CNT_W-1:0] cfg_num_cols,
    input  logic             row_rdy,
    input  logic             stall,
    output logic             busy,
    output logic             done,
    output logic [1:0]       gray_code,
    output logic             sequence_selector,
    output logic [2:0]       seq_data_addr,
    output logic             seq_valid,
    output logic             wht_addr_valid
);

    localparam int c_ADDR_W = 3;

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    logic [CNT_W-1:0] r_cfg_rows;
    logic [CNT_W-1:0] r_cfg_cols;
    logic [1:0]       r_gray;
    logic             r_sel;
    logic             r_wht_valid;

    logic             w_start_ok;
    logic             w_issue;
    logic             w_addr_wrap;
    logic             w_row_end;
    logic             w_pass_end;
    logic [CNT_W-1:0] w_cols_last;
    logic [CNT_W-1:0] w_rows_last;
    logic [c_ADDR_W-1:0] w_addr_cnt;
    logic [CNT_W-1:0] w_unused_col_cnt;
    logic [CNT_W-1:0] w_unused_row_cnt;

    assign w_start_ok  = (r_state == ST_IDLE) && start;
    assign w_issue     = (r_state == ST_SEQ) && !stall;
    assign w_cols_last = r_cfg_cols - 1'b1;
    assign w_rows_last = r_cfg_rows - 1'b1;

    // Index within the current column group
    cnn_layer_accel_wrap_counter #(
        .WIDTH   (c_ADDR_W),
        .MODULUS (SEQ_LEN)
    ) u_addr_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (w_issue),
        .clr      (w_start_ok),
        .last_val ({c_ADDR_W{1'b0}}),
        .count    (w_addr_cnt),
        .wrap     (w_addr_wrap)
    );

    // Column group within the current row; its wrap marks the row-final issue
    cnn_layer_accel_wrap_counter #(
        .WIDTH   (CNT_W),
        .MODULUS (0)
    ) u_col_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (w_addr_wrap),
        .clr      (w_start_ok),
        .last_val (w_cols_last),
        .count    (w_unused_col_cnt),
        .wrap     (w_row_end)
    );

    // Row within the pass; its wrap marks the pass-final issue
    cnn_layer_accel_wrap_counter #(
        .WIDTH   (CNT_W),
        .MODULUS (0)
    ) u_row_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (w_row_end),
        .clr      (w_start_ok),
        .last_val (w_rows_last),
        .count    (w_unused_row_cnt),
        .wrap     (w_pass_end)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_next_state = r_state;
        busy         = (r_state != ST_IDLE);
        done         = (r_state == ST_DONE);
        seq_valid    = w_issue;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ((cfg_num_rows != '0) && (cfg_num_cols != '0)) ? ST_ROW_WAIT : ST_DONE;
                end
            end
            ST_ROW_WAIT: begin
                if (row_rdy) begin
                    w_next_state = ST_SEQ;
                end
            end
            ST_SEQ: begin
                if (w_row_end) begin
                    w_next_state = w_pass_end ? ST_DONE : ST_ROW_WAIT;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Pass configuration is captured only when a start is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_rows <= '0;
            r_cfg_cols <= '0;
        end else if (w_start_ok) begin
            r_cfg_rows <= cfg_num_rows;
            r_cfg_cols <= cfg_num_cols;
        end
    end

    // Row phase: restarts each pass, steps after every row-final issue
    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_gray <= 2'b00;
        end else if (w_row_end) begin
            r_gray <= gray_next(r_gray);
        end
    end

    // Column-group parity: flips per group, forced back to 1 at each row start
    always_ff @(posedge clk) begin
        if (rst || w_start_ok || w_row_end) begin
            r_sel <= 1'b1;
        end else if (w_addr_wrap) begin
            r_sel <= ~r_sel;
        end
    end

    // Align issue strobe with the registered weight-table read data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wht_valid <= 1'b0;
        end else begin
            r_wht_valid <= w_issue;
        end
    end

    assign gray_code         = r_gray;
    assign sequence_selector = r_sel;
    assign seq_data_addr     = w_addr_cnt;
    assign wht_addr_valid    = r_wht_valid;

endmodule
`default_nettype wire

// File: tb/tb_cnn_layer_accel_weight_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnn_layer_accel_weight_seq_ctrl
// Description : Scoreboard bench for the weight-sequence controller. The
//               expected issue stream is pushed when a pass is started and
//               popped on every observed issue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_layer_accel_weight_seq_ctrl;

    localparam int CNT_W = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] cfg_num_rows;
    logic [CNT_W-1:0] cfg_num_cols;
    logic             row_rdy;
    logic             stall;
    logic             busy;
    logic             done;
    logic [1:0]       gray_code;
    logic             sequence_selector;
    logic [2:0]       seq_data_addr;
    logic             seq_valid;
    logic             wht_addr_valid;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int issue_cnt = 0;
    int done_cnt = 0;
    int last_issue_cyc = 0;
    int done_cyc = 0;
    logic prev_sv = 1'b0;
    logic [31:0] sb_q [$];

    cnn_layer_accel_weight_seq_ctrl #(
        .SEQ_LEN (5),
        .CNT_W   (CNT_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .cfg_num_rows      (cfg_num_rows),
        .cfg_num_cols      (cfg_num_cols),
        .row_rdy           (row_rdy),
        .stall             (stall),
        .busy              (busy),
        .done              (done),
        .gray_code         (gray_code),
        .sequence_selector (sequence_selector),
        .seq_data_addr     (seq_data_addr),
        .seq_valid         (seq_valid),
        .wht_addr_valid    (wht_addr_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] exp_gray(input int row);
        case (row % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    // Issue monitor: pops the scoreboard on every issue, checks the delayed strobe
    always @(negedge clk) begin
        if (rst) begin
            prev_sv = 1'b0;
        end else begin
            check("wht_addr_valid", {31'd0, wht_addr_valid}, {31'd0, prev_sv});
            if (seq_valid) begin
                issue_cnt++;
                last_issue_cyc = cyc;
                check("issue", {26'd0, gray_code, sequence_selector, seq_data_addr},
                      (sb_q.size() == 0) ? 32'hFFFF_FFFF : sb_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_sv = seq_valid;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        row_rdy = 1'b1;
        cfg_num_rows = '0;
        cfg_num_cols = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {23'd0, busy, done, gray_code, sequence_selector, seq_data_addr, seq_valid, wht_addr_valid},
              {23'd0, 1'b0, 1'b0, 2'b00, 1'b1, 3'd0, 1'b0, 1'b0});
        @(posedge clk);
        #1 rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic start_pass(input int rows, input int cols);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++)
                for (int a = 0; a < 5; a++)
                    sb_q.push_back({26'd0, exp_gray(r), (c % 2 == 0), 3'(a)});
        issue_cnt = 0;
        done_cnt = 0;
        @(posedge clk);
        #1;
        cfg_num_rows = CNT_W'(rows);
        cfg_num_cols = CNT_W'(cols);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cfg_num_rows = CNT_W'($urandom_range(1, 9));
        cfg_num_cols = CNT_W'($urandom_range(1, 9));
    endtask

    task automatic wait_done(input string tag, input int exp_issues);
        int guard = 0;
        while (done_cnt == 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 2000) check({tag, "_done_timeout"}, 32'(guard), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_issues"}, 32'(issue_cnt), 32'(exp_issues));
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_latency"}, 32'(done_cyc - last_issue_cyc), 32'd1);
        check({tag, "_sb_left"}, 32'(sb_q.size()), 32'd0);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic stall_at(input int addr, input int cycles, input logic [1:0] gray);
        int guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (!(seq_valid && seq_data_addr == 3'(addr)) && guard < 200);
        if (guard >= 200) check("stall_wait_timeout", 32'(guard), 32'd0);
        stall = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("stall_addr_hold", {29'd0, seq_data_addr}, 32'(addr));
            check("stall_seq_valid", {31'd0, seq_valid}, 32'd0);
            check("stall_gray_hold", {30'd0, gray_code}, {30'd0, gray});
            check("stall_busy", {31'd0, busy}, 32'd1);
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;

        // Basic pass, with a start pulse mid-pass that must be ignored
        do_reset();
        start_pass(2, 2);
        repeat (8) @(posedge clk);
        #1;
        cfg_num_rows = 10'd7;
        cfg_num_cols = 10'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("basic", 20);

        // Gray wrap over five single-group rows
        do_reset();
        start_pass(5, 1);
        wait_done("gray", 25);

        // Mid-group stall, then a stall on the row-final issue
        do_reset();
        start_pass(2, 1);
        stall_at(2, 3, 2'b00);
        stall_at(4, 2, 2'b00);
        wait_done("stall", 10);

        // Row buffer not ready between rows
        do_reset();
        start_pass(2, 1);
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (!(seq_valid && seq_data_addr == 3'd3) && guard < 200);
        row_rdy = 1'b0;
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (seq_valid && guard < 200);
        if (guard >= 200) check("row_wait_timeout", 32'(guard), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("row_wait_state", {29'd0, busy, seq_valid, 1'b0}, {29'd0, 1'b1, 1'b0, 1'b0});
            check("row_wait_gray", {30'd0, gray_code}, 32'd1);
            @(posedge clk);
            #1;
        end
        row_rdy = 1'b1;
        wait_done("row_wait", 10);

        // Zero configuration in either dimension: no issues, immediate done
        for (int z = 0; z < 2; z++) begin
            do_reset();
            issue_cnt = 0;
            @(posedge clk);
            #1;
            cfg_num_rows = (z == 0) ? 10'd3 : 10'd0;
            cfg_num_cols = (z == 0) ? 10'd0 : 10'd3;
            start = 1'b1;
            @(negedge clk);
            check("zero_done_start_cycle", {31'd0, done}, 32'd0);
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            check("zero_done_next_cycle", {30'd0, busy, done}, 32'd3);
            @(negedge clk);
            check("zero_done_after", {30'd0, busy, done}, 32'd0);
            check("zero_issues", 32'(issue_cnt), 32'd0);
        end

        // Reset mid-pass, then a full pass
        do_reset();
        start_pass(3, 3);
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (issue_cnt < 6 && guard < 500);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_outputs", {23'd0, busy, done, gray_code, sequence_selector, seq_data_addr, seq_valid, wht_addr_valid},
              {23'd0, 1'b0, 1'b0, 2'b00, 1'b1, 3'd0, 1'b0, 1'b0});
        @(posedge clk);
        #1 rst = 1'b0;
        sb_q.delete();
        done_cnt = 0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_idle", {31'd0, busy}, 32'd0);
        start_pass(3, 3);
        wait_done("restart", 45);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
